sbox_bank_arbiter: RTL
======================

Name: sbox_bank_arbiter

Overview:
- Shares one bank of combinational S-box lookups between two requesters: key expansion (SubWord, 32 bits) and the cipher round (SubBytes, 128 bits).
- Accepts one request at a time through a valid/ready handshake and arbitrates round-robin when both requesters are valid.
- Drives the bank lanes over one or more passes and returns the substituted data as a one-cycle response pulse.
- Sits in the cipher top level, between the key-expansion unit, the round datapath and the NUM_SBOX sbox instances.

Parameters:
- NUM_SBOX, 4, number of sbox instances in the bank; legal values are 4, 8 and 16.
- BYTE, 8, byte width, taken from aes_package.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ks_req_valid  in  1  key-expansion request valid.
- ks_req_word  in  32  word to substitute.
- ks_req_ready  out  1  key-expansion request accepted this cycle.
- ks_rsp_valid  out  1  one-cycle pulse: ks_rsp_word is valid.
- ks_rsp_word  out  32  substituted word.
- cp_req_valid  in  1  cipher request valid.
- cp_req_state  in  128  state to substitute.
- cp_req_ready  out  1  cipher request accepted this cycle.
- cp_rsp_valid  out  1  one-cycle pulse: cp_rsp_state is valid.
- cp_rsp_state  out  128  substituted state.
- sb_addr  out  NUM_SBOX*BYTE  bank inputs; lane i is bits [8i+7:8i].
- sb_dout  in  NUM_SBOX*BYTE  bank outputs, combinational from sb_addr.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, rst_n low):
  - FSM goes to IDLE; pass counter = 0; priority pointer = KS.
  - All outputs = 0, including the response data registers.
  - Any in-flight request is dropped and produces no response.
- FSM states: IDLE, KS_SUB, CP_SUB, RESP.
- IDLE:
  - Readies are combinational: ks_req_ready/cp_req_ready = IDLE and that requester is granted. Readies are 0 in every other state.
  - Grant rule: the only valid requester wins. If both are valid, the requester indicated by the priority pointer wins.
  - On handshake (valid && ready at the clock edge), request data is captured into an internal register.
  - The priority pointer then moves to the other requester.
  - Next state is KS_SUB or CP_SUB.
  - Request inputs are ignored after capture.
- KS_SUB (1 cycle):
  - Lanes 0..3 = captured word bytes 0..3; lanes 4 and above = 8'h00.
  - sb_dout lanes 0..3 are registered into ks_rsp_word.
  - Next state is RESP.
- CP_SUB (PASSES = 16/NUM_SBOX cycles):
  - In pass p, lane i = state byte p*NUM_SBOX+i.
  - Results are registered into the same byte positions of cp_rsp_state.
  - The counter increments each cycle. After pass PASSES-1, the counter clears and next state is RESP.
- RESP (1 cycle):
  - The served port's rsp_valid = 1 for exactly one cycle. Next state is IDLE.
  - No response back-pressure exists; requesters must accept the pulse.
- Response data registers hold their value until that port's next response.
- Outside KS_SUB/CP_SUB, sb_addr = 0.
- Latency, measured from the accept edge to the cycle in which rsp_valid is high:
  - KS: 2 cycles.
  - CP: PASSES+1 cycles (5 cycles at NUM_SBOX=4).
- Throughput: the next request can be accepted in the IDLE cycle after RESP.
- Simultaneous valids on both ports while busy: both wait, and the grant follows the pointer once IDLE is reached.
- A valid that drops before ready is not captured; no response is produced.

Test Plan:
- KS only, ks_req_word=0x03020100 -> ks_rsp_word=0x7b777c63; ks_rsp_valid pulses once, 2 cycles after accept; cp_rsp_valid stays 0.
- CP only, NUM_SBOX=4, cp_req_state=0x00112233445566778899aabbccddeeff -> cp_rsp_state=0x638293c31bfc33f5c4eeacea4bc12816; cp_rsp_valid pulses 5 cycles after accept; busy is high for 5 cycles.
- Both valid held from reset -> grant order KS, CP, KS, CP; each ready pulses only in IDLE; no two responses occur in the same cycle.
- rst_n asserted during CP pass 2 -> all outputs go to 0 immediately; no cp_rsp_valid after release; a following KS request of 0xffffffff returns 0x16161616.
- cp_req_state changed the cycle after accept -> response reflects the captured value only.
- NUM_SBOX=16, CP request of all 0x52 bytes -> all 0x00 bytes with 2-cycle latency; sb_addr lanes 4-15 = 0 during KS_SUB.

Source files
------------

// File: rtl/sbox_bank_arbiter.sv
// Round-robin arbiter sharing one bank of combinational S-boxes between key expansion
// (32-bit SubWord) and the cipher round (128-bit SubBytes), one request at a time.
module sbox_bank_arbiter #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ks_req_valid,
    input  logic [31:0]              ks_req_word,
    output logic                     ks_req_ready,
    output logic                     ks_rsp_valid,
    output logic [31:0]              ks_rsp_word,
    input  logic                     cp_req_valid,
    input  logic [127:0]             cp_req_state,
    output logic                     cp_req_ready,
    output logic                     cp_rsp_valid,
    output logic [127:0]             cp_rsp_state,
    output logic [NUM_SBOX*8-1:0]    sb_addr,
    input  logic [NUM_SBOX*8-1:0]    sb_dout,
    output logic                     busy
);

    localparam int unsigned BYTE   = 8;
    localparam int unsigned PASSES = 16 / NUM_SBOX;
    localparam int unsigned CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_KS   = 2'd1;
    localparam logic [1:0] S_CP   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic PORT_KS = 1'b0;
    localparam logic PORT_CP = 1'b1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             served_q, served_d;
    logic [127:0]     data_q, data_d;
    logic [31:0]      ks_word_q, ks_word_d;
    logic [127:0]     cp_state_q, cp_state_d;

    logic grant_ks_c;
    logic grant_cp_c;

    // Sole valid requester wins; on a tie the priority pointer decides.
    always_comb begin
        grant_ks_c = ks_req_valid && (!cp_req_valid || (ptr_q == PORT_KS));
        grant_cp_c = cp_req_valid && (!ks_req_valid || (ptr_q == PORT_CP));
    end

    // Readies are gated by rst_n so nothing looks accepted while reset is held.
    assign ks_req_ready = rst_n && (state_q == S_IDLE) && grant_ks_c;
    assign cp_req_ready = rst_n && (state_q == S_IDLE) && grant_cp_c;
    assign ks_rsp_valid = (state_q == S_RESP) && (served_q == PORT_KS);
    assign cp_rsp_valid = (state_q == S_RESP) && (served_q == PORT_CP);
    assign ks_rsp_word  = ks_word_q;
    assign cp_rsp_state = cp_state_q;
    assign busy         = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= PORT_KS;
            served_q   <= PORT_KS;
            data_q     <= '0;
            ks_word_q  <= '0;
            cp_state_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            served_q   <= served_d;
            data_q     <= data_d;
            ks_word_q  <= ks_word_d;
            cp_state_q <= cp_state_d;
        end
    end

    always_comb begin
        int unsigned base;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        served_d   = served_q;
        data_d     = data_q;
        ks_word_d  = ks_word_q;
        cp_state_d = cp_state_q;
        sb_addr    = '0;
        base       = 32'(cnt_q) * NUM_SBOX;

        case (state_q)
            S_IDLE: begin
                if (grant_ks_c) begin
                    data_d   = {96'h0, ks_req_word};
                    served_d = PORT_KS;
                    ptr_d    = PORT_CP;
                    state_d  = S_KS;
                end else if (grant_cp_c) begin
                    data_d   = cp_req_state;
                    served_d = PORT_CP;
                    ptr_d    = PORT_KS;
                    state_d  = S_CP;
                end
            end
            S_KS: begin
                for (int i = 0; i < 4; i++) begin
                    sb_addr[i*BYTE +: BYTE] = data_q[i*BYTE +: BYTE];
                end
                ks_word_d = sb_dout[31:0];
                state_d   = S_RESP;
            end
            S_CP: begin
                // Pass p substitutes state bytes p*NUM_SBOX .. p*NUM_SBOX+NUM_SBOX-1 in place.
                for (int i = 0; i < int'(NUM_SBOX); i++) begin
                    sb_addr[i*BYTE +: BYTE] = data_q[(base + 32'(i))*BYTE +: BYTE];
                    cp_state_d[(base + 32'(i))*BYTE +: BYTE] = sb_dout[i*BYTE +: BYTE];
                end
                if (cnt_q == CNT_W'(PASSES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
